// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back gets priority, multi-cycle-unit
// results wait in a small FIFO, and a starving head raises stall_req to force its write.
module regfile_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_pc,
    input  logic        mcu_valid,
    output logic        mcu_ready,
    input  logic [4:0]  mcu_waddr,
    input  logic [31:0] mcu_wdata,
    input  logic [31:0] mcu_pc,
    input  logic [4:0]  fwd_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        debug_reg_write_en,
    output logic [31:0] debug_pc_addr_out,
    output logic        stall_req
);

    localparam int         SLOTS   = 4;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [4:0]  addr_q [SLOTS];
    logic [31:0] data_q [SLOTS];
    logic [31:0] pc_q   [SLOTS];

    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [3:0]  wait_q, wait_d;
    logic        stall_q, stall_d;

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [31:0] rf_pc_q, rf_pc_d;

    logic        pipe_req;
    logic        head_grant;
    logic        push;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [2:0] nxt;
        nxt = {1'b0, p} + 3'd1;
        if (nxt >= DEPTH_C) begin
            nxt = 3'd0;
        end
        return 2'(nxt);
    endfunction

    // MCU handshake: a result transfers on a rising edge where mcu_valid && mcu_ready.
    // mcu_ready depends only on queue occupancy and reset, never on mcu_valid.
    assign mcu_ready = rst_n && (count_q < DEPTH_C);
    assign push      = mcu_valid && mcu_ready && (mcu_waddr != 5'd0);

    // While stalled the held WB inputs are ignored so the starving head owns the port.
    assign pipe_req   = wb_we && (wb_waddr != 5'd0) && !stall_q;
    assign head_grant = (count_q != 3'd0) && (!pipe_req || stall_q);

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = 32'd0;
        rf_pc_d    = 32'd0;
        if (pipe_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_waddr;
            rf_wdata_d = wb_wdata;
            rf_pc_d    = wb_pc;
        end else if (head_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
            rf_pc_d    = pc_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (head_grant) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        case ({push, head_grant})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // A granted head always clears the stall, so the counter never passes the limit.
    always_comb begin
        wait_d = 4'd0;
        if ((count_q != 3'd0) && !head_grant) begin
            wait_d = wait_q + 4'd1;
        end
        stall_d = (wait_d >= LIMIT_C);
    end

    always_comb begin
        logic [2:0] slot3;
        logic [1:0] slot;
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        slot3    = 3'd0;
        slot     = 2'd0;
        for (int k = 0; k < DEPTH; k++) begin
            slot3 = {1'b0, rd_ptr_q} + 3'(k);
            if (slot3 >= DEPTH_C) begin
                slot3 = slot3 - DEPTH_C;
            end
            slot = 2'(slot3);
            // Oldest to youngest, so the last match is the newest value.
            if ((3'(k) < count_q) && (addr_q[slot] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[slot];
            end
        end
        if (fwd_addr == 5'd0) begin
            fwd_hit  = 1'b0;
            fwd_data = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
                pc_q[i]   <= 32'd0;
            end
        end else if (push) begin
            addr_q[wr_ptr_q] <= mcu_waddr;
            data_q[wr_ptr_q] <= mcu_wdata;
            pc_q[wr_ptr_q]   <= mcu_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            wait_q     <= 4'd0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            rf_pc_q    <= 32'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_pc_q    <= rf_pc_d;
        end
    end

    assign rf_we              = rf_we_q;
    assign rf_waddr           = rf_waddr_q;
    assign rf_wdata           = rf_wdata_q;
    assign debug_reg_write_en = rf_we_q;
    assign debug_pc_addr_out  = rf_pc_q;
    assign stall_req          = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic [31:0] wb_pc = '0;
  logic        mcu_valid = 1'b0;
  logic        mcu_ready;
  logic [4:0]  mcu_waddr = '0;
  logic [31:0] mcu_wdata = '0;
  logic [31:0] mcu_pc = '0;
  logic [4:0]  fwd_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        debug_reg_write_en;
  logic [31:0] debug_pc_addr_out;
  logic        stall_req;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .mcu_waddr(mcu_waddr),
    .mcu_wdata(mcu_wdata), .mcu_pc(mcu_pc),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_reg_write_en(debug_reg_write_en), .debug_pc_addr_out(debug_pc_addr_out),
    .stall_req(stall_req)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: pending MCU entries {addr, data, pc}, oldest first
  logic [68:0] exp_q[$];
  int          m_wait = 0;
  logic        m_stall = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pc = '0;
  int          total = 0;
  int          bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, ".rf_we"}, 32'(rf_we), 32'(m_we));
    check_val({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(m_addr));
    check_val({tag, ".rf_wdata"}, rf_wdata, m_data);
    check_val({tag, ".dbg_we"}, 32'(debug_reg_write_en), 32'(m_we));
    check_val({tag, ".dbg_pc"}, debug_pc_addr_out, m_pc);
    check_val({tag, ".stall"}, 32'(stall_req), 32'(m_stall));
  endtask

  // one clock: check combinational outputs, advance model, check registered outputs
  task automatic step(input string tag);
    logic        e_hit, pipe, head, push;
    logic [31:0] e_fd;
    logic [68:0] e;
    int          sz;
    #1;
    sz = exp_q.size();
    check_val({tag, ".mcu_ready"}, 32'(mcu_ready), 32'(sz < DEPTH));
    e_hit = 1'b0;
    e_fd  = 32'd0;
    if (fwd_addr != 5'd0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i][68:64] == fwd_addr) begin
          e_hit = 1'b1;
          e_fd  = exp_q[i][63:32];
        end
      end
    end
    check_val({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(e_hit));
    check_val({tag, ".fwd_data"}, fwd_data, e_fd);

    pipe = wb_we && (wb_waddr != 5'd0) && !m_stall;
    head = (sz > 0) && (!pipe || m_stall);
    push = mcu_valid && (sz < DEPTH) && (mcu_waddr != 5'd0);
    e = '0;
    if (head) e = exp_q.pop_front();
    if (push) exp_q.push_back({mcu_waddr, mcu_wdata, mcu_pc});
    if (sz == 0 || head) m_wait = 0;
    else m_wait = m_wait + 1;
    if (head) m_stall = 1'b0;
    else if (m_wait >= LIMIT) m_stall = 1'b1;

    @(posedge clk);
    #1;
    if (pipe) begin
      m_we = 1'b1; m_addr = wb_waddr; m_data = wb_wdata; m_pc = wb_pc;
    end else if (head) begin
      m_we = 1'b1; m_addr = e[68:64]; m_data = e[63:32]; m_pc = e[31:0];
    end else begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
    end
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    // upstream holds its write-back inputs while the model says stall is up
    if (!m_stall) begin
      wb_we = we; wb_waddr = a; wb_wdata = d; wb_pc = pc;
    end
  endtask

  task automatic drive_mcu(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    mcu_valid = v; mcu_waddr = a; mcu_wdata = d; mcu_pc = pc;
  endtask

  task automatic idle();
    drive_wb(1'b0, 5'd0, 32'd0, 32'd0);
    drive_mcu(1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int k;
    // reset state
    #2;
    check_val("reset.mcu_ready", 32'(mcu_ready), 32'd0);
    check_regs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single pipeline write to r5
    drive_wb(1'b1, 5'd5, 32'h11, 32'h1000);
    step("wb5");
    idle();
    step("wb5_idle");

    // MCU result to r7, forwarded while queued, then written
    fwd_addr = 5'd7;
    drive_mcu(1'b1, 5'd7, 32'hAB, 32'h2000);
    step("mcu7_push");
    drive_mcu(1'b0, 5'd0, 32'd0, 32'd0);
    step("mcu7_fwd");
    step("mcu7_done");

    // starvation: one queued entry under continuous pipeline writes
    fwd_addr = 5'd12;
    drive_wb(1'b1, 5'd9, 32'h900, 32'h3000);
    drive_mcu(1'b1, 5'd12, 32'hC0C0, 32'h3004);
    step("starve_push");
    drive_mcu(1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) begin
      drive_wb(1'b1, 5'(9 + (i % 3)), 32'h901 + 32'(i), 32'h3008 + 32'(4 * i));
      step("starve");
    end
    idle();
    step("starve_idle");

    // full FIFO: three results to r3 under continuous pipeline writes
    fwd_addr = 5'd3;
    k = 1;
    for (int i = 0; i < 24; i++) begin
      drive_wb(1'b1, 5'd20, 32'h5000 + 32'(i), 32'h4000 + 32'(4 * i));
      if (k <= 3) drive_mcu(1'b1, 5'd3, 32'(k), 32'h4800 + 32'(k));
      else drive_mcu(1'b0, 5'd0, 32'd0, 32'd0);
      // the source advances only after its result is accepted
      if (k <= 3 && exp_q.size() < DEPTH) k++;
      step("full");
    end
    idle();
    for (int i = 0; i < 4; i++) step("full_drain");

    // r0 writes from both sources are dropped
    fwd_addr = 5'd0;
    drive_wb(1'b1, 5'd0, 32'hDEAD, 32'h6000);
    drive_mcu(1'b1, 5'd0, 32'hBEEF, 32'h6004);
    step("r0");
    idle();
    step("r0_after");

    // reset mid-operation with two entries queued
    fwd_addr = 5'd14;
    drive_wb(1'b1, 5'd1, 32'h71, 32'h7000);
    drive_mcu(1'b1, 5'd14, 32'h714, 32'h7004);
    step("rst_fill");
    drive_wb(1'b1, 5'd2, 32'h72, 32'h7008);
    drive_mcu(1'b1, 5'd15, 32'h715, 32'h700C);
    step("rst_fill");
    idle();
    drive_wb(1'b1, 5'd3, 32'h73, 32'h7010);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_wait = 0; m_stall = 1'b0;
    m_we = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
    check_regs("rst_async");
    check_val("rst_async.mcu_ready", 32'(mcu_ready), 32'd0);
    check_val("rst_async.fwd_hit", 32'(fwd_hit), 32'd0);
    @(posedge clk);
    #1;
    check_regs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step("rst_release");
    step("rst_release2");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_wb($urandom_range(0, 9) < 7, 5'($urandom_range(0, 9)), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1)
        drive_mcu(1'b1, 5'($urandom_range(0, 7)), $urandom, $urandom);
      else
        drive_mcu(1'b0, 5'd0, 32'd0, 32'd0);
      fwd_addr = 5'($urandom_range(0, 7));
      step("rand");
    end
    idle();
    for (int i = 0; i < 6; i++) step("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter line: DEPTH, 2, number of pending multi-cycle-unit (MCU) result entries, legal range 1-4.
REQ-002 Parameter line: STARVE_LIMIT, 4, cycles a queued entry may be denied the port before a stall is requested, legal range 1-15.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, listed first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-004 The pipeline write-back inputs SHALL be:
- wb_we  in  1  pipeline write request
- wb_waddr  in  5  destination register
- wb_wdata  in  32  write data
- wb_pc  in  32  PC of the writing instruction
REQ-005 The MCU result port SHALL be:
- mcu_valid  in  1  result offered
- mcu_ready  out  1  result accepted this cycle
- mcu_waddr  in  5  destination register
- mcu_wdata  in  32  result data
- mcu_pc  in  32  PC of the producing instruction
REQ-006 The forwarding port SHALL be:
- fwd_addr  in  5  query register
- fwd_hit  out  1  pending entry matches the query
- fwd_data  out  32  data of the newest match
REQ-007 The register-file port and stall output SHALL be:
- rf_we  out  1  write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- debug_reg_write_en  out  1  equals rf_we
- debug_pc_addr_out  out  32  PC of the instruction being written
- stall_req  out  1  pipeline freeze request

Function
REQ-008 rf_we, rf_waddr, rf_wdata, debug_reg_write_en, debug_pc_addr_out and stall_req SHALL be registered; a grant at edge N SHALL appear on these outputs after edge N (1-cycle latency).
REQ-009 A pipeline request (wb_we=1, wb_waddr!=0) with stall_req=0 SHALL always be granted; a pipeline write to r0 SHALL be dropped and the port treated as free.
REQ-010 The queue head SHALL be granted whenever the port is free, or whenever stall_req=1 regardless of wb_we.
REQ-011 While stall_req=1, upstream holds its WB inputs steady; the arbiter SHALL ignore them that cycle and the held write SHALL be granted after stall_req falls.
REQ-012 MCU results SHALL go into a FIFO of DEPTH entries; mcu_ready SHALL be 1 iff count<DEPTH and rst_n=1; a handshake occurs when mcu_valid&&mcu_ready.
REQ-013 A handshaken result with mcu_waddr=0 SHALL be accepted and discarded without being enqueued.
REQ-014 A push and a pop in the same cycle SHALL leave count unchanged; when count=DEPTH there is no push, because mcu_ready=0 (no push/pop bypass).
REQ-015 The head's wait counter SHALL increment each cycle the queue is non-empty and the head is not granted; it SHALL clear on a head grant or when the queue is empty.
REQ-016 stall_req SHALL assert at the edge where the wait counter reaches STARVE_LIMIT, and SHALL deassert at the edge following the head grant.
REQ-017 fwd_hit/fwd_data SHALL be combinational: fwd_hit=1 iff fwd_addr!=0 and a valid entry has that address; fwd_data SHALL be the youngest matching entry's data, and 0 when fwd_hit=0.
REQ-018 Entries SHALL leave the queue strictly in FIFO order; pointers SHALL wrap modulo DEPTH.
REQ-019 When idle (no grant), rf_we=0 and rf_waddr, rf_wdata and debug_pc_addr_out SHALL be 0.

Reset
REQ-020 While rst_n=0, all registered outputs and mcu_ready SHALL be 0, and the queue, count, pointers and wait counter SHALL be cleared, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard all queued entries with no partial write; the first edge after release SHALL produce no write.

Verification
REQ-022 wb_we=1, addr 5, data 0x11 with queue empty -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11, debug_pc_addr_out=wb_pc.
REQ-023 MCU pushes addr 7, data 0xAB while wb_we=0 -> fwd_hit=1 for fwd_addr=7 while queued; rf_we=1 (addr 7, 0xAB) one cycle after the grant.
REQ-024 Pipeline writes every cycle with one entry queued, STARVE_LIMIT=4 -> stall_req=1 after 4 denied cycles; the head is written next, stall_req=0 the following cycle, and the held pipeline write is then granted.
REQ-025 DEPTH=2: three back-to-back MCU results to addr 3 (0x1, 0x2, 0x3) under continuous pipeline writes -> mcu_ready=0 on the third; fwd_data=0x2; writes then drain in order 0x1, 0x2, 0x3.
REQ-026 MCU result to r0 and pipeline write to r0 -> no rf_we, count stays 0; rst_n pulsed low with 2 entries queued -> outputs 0 at once, queue empty, no write after release.
